sel_sequencer: RTL and testbench

SEL_SEQUENCER -- requirements
Module: sel_sequencer

---
 rtl/sel_sequencer.sv | 166 ++++++++++++++++
 tb/tb_sel_sequencer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/sel_sequencer.sv
// Channel-select scan sequencer that dwells on each channel and drives a 3-to-8 decoder index.
// Optional build macro SEL_SEQ_SKIP_EN: honour the channel mask (skip disabled channels, reject empty mask).
module sel_sequencer #(
  parameter int unsigned DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               pause,
  input  logic               cont,
  input  logic [7:0]         mask,
  input  logic [DWELL_W-1:0] dwell,
  output logic [2:0]         sel,
  output logic               sel_valid,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int unsigned NCH = 8;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_DWELL = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         sel_q, sel_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [NCH-1:0]     mask_q, mask_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               cont_q, cont_d;
  logic               active_q, active_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic [NCH-1:0]     start_mask_c;
  logic               start_ok_c;

  // Lowest enabled channel index in m (0 when m is empty).
  function automatic logic [2:0] lowest(input logic [NCH-1:0] m);
    lowest = 3'd0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (m[i]) lowest = 3'(i);
    end
  endfunction

  // True when some enabled channel lies strictly above s.
  function automatic logic has_above(input logic [NCH-1:0] m, input logic [2:0] s);
    has_above = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (m[i] && (i > int'(s))) has_above = 1'b1;
    end
  endfunction

  // Nearest enabled channel strictly above s (s itself if none).
  function automatic logic [2:0] next_above(input logic [NCH-1:0] m, input logic [2:0] s);
    next_above = s;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (m[i] && (i > int'(s))) next_above = 3'(i);
    end
  endfunction

`ifdef SEL_SEQ_SKIP_EN
  assign start_mask_c = mask;
  assign start_ok_c   = |mask;
`else
  logic unused_mask;
  assign unused_mask  = ^mask;
  assign start_mask_c = {NCH{1'b1}};
  assign start_ok_c   = 1'b1;
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    dwell_d = dwell_q;
    cont_d  = cont_q;
    err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        sel_d = 3'd0;
        if (start && !stop) begin
          if (start_ok_c) begin
            mask_d  = start_mask_c;
            dwell_d = dwell;
            cont_d  = cont;
            sel_d   = lowest(start_mask_c);
            cnt_d   = dwell;
            state_d = S_DWELL;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      S_DWELL: begin
        if (stop) begin
          state_d = S_IDLE;
          sel_d   = 3'd0;
          cnt_d   = '0;
        end else if (!pause) begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - DWELL_W'(1);
          end else if (has_above(mask_q, sel_q)) begin
            sel_d = next_above(mask_q, sel_q);
            cnt_d = dwell_q;
          end else if (cont_q) begin
            sel_d = lowest(mask_q);
            cnt_d = dwell_q;
          end else begin
            state_d = S_IDLE;
            sel_d   = 3'd0;
            cnt_d   = '0;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        sel_d   = 3'd0;
        cnt_d   = '0;
      end
    endcase

    active_d = (state_d == S_DWELL);
    // done marks the final count of the last enabled channel, i.e. the cycle the scan wraps
    done_d   = active_d && (cnt_d == '0) && !has_above(mask_d, sel_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      sel_q    <= 3'd0;
      cnt_q    <= '0;
      mask_q   <= '0;
      dwell_q  <= '0;
      cont_q   <= 1'b0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      mask_q   <= mask_d;
      dwell_q  <= dwell_d;
      cont_q   <= cont_d;
      active_q <= active_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign sel       = sel_q;
  assign sel_valid = active_q;
  assign busy      = active_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_sel_sequencer.sv
// Directed self-checking bench for sel_sequencer; SEL_SEQ_SKIP_EN-only steps are guarded by the same macro.
module tb_sel_sequencer;

  localparam int unsigned DWELL_W = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic               stop;
  logic               pause;
  logic               cont;
  logic [7:0]         mask;
  logic [DWELL_W-1:0] dwell;
  logic [2:0]         sel;
  logic               sel_valid;
  logic               busy;
  logic               done;
  logic               err;

  int checks = 0;
  int errors = 0;

  sel_sequencer #(.DWELL_W(DWELL_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .pause     (pause),
    .cont      (cont),
    .mask      (mask),
    .dwell     (dwell),
    .sel       (sel),
    .sel_valid (sel_valid),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Compare {sel, sel_valid, busy, done, err} against hand-computed values.
  task automatic expect_out(input string tag, input logic [2:0] e_sel, input logic e_v,
                            input logic e_b, input logic e_d, input logic e_e);
    logic [6:0] obs;
    logic [6:0] exp;
    obs = {sel, sel_valid, busy, done, err};
    exp = {e_sel, e_v, e_b, e_d, e_e};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed sel=%0d v=%b b=%b d=%b e=%b expected sel=%0d v=%b b=%b d=%b e=%b",
             tag, obs[6:4], obs[3], obs[2], obs[1], obs[0],
             exp[6:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

`ifdef SEL_SEQ_SKIP_EN
  logic [2:0] seq31 [3] = '{3'd2, 3'd5, 3'd7};
`endif

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0;
    cont = 1'b0; mask = 8'hFF; dwell = '0;
    step();
    step();
    expect_out("reset_held", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    step();
    expect_out("reset_idle", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Full one-shot scan, dwell=2: 24 valid cycles, done on the last with sel=7.
    dwell = 8'd2; mask = 8'hFF; cont = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 24; k++) begin
      expect_out($sformatf("scan_d2_c%0d", k), 3'(k / 3), 1'b1, 1'b1, (k == 23), 1'b0);
      step();
    end
    expect_out("scan_d2_idle", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();

    // Pause 4 cycles on channel 1 with dwell=3: channel 1 held 8, others 4.
    dwell = 8'd3; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 36; c++) begin
      logic [2:0] es;
      pause = (c >= 5 && c <= 8);
      if (c < 4)       es = 3'd0;
      else if (c < 12) es = 3'd1;
      else             es = 3'(2 + (c - 12) / 4);
      expect_out($sformatf("pause_c%0d", c), es, 1'b1, 1'b1, (c == 35), 1'b0);
      step();
    end
    pause = 1'b0;
    expect_out("pause_idle", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Config changes and a second start mid-scan are ignored.
    dwell = 8'd1; cont = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (k == 3) begin
        dwell = 8'd5; cont = 1'b1; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      expect_out($sformatf("busy_start_c%0d", k), 3'(k / 2), 1'b1, 1'b1, (k == 15), 1'b0);
      step();
    end
    expect_out("busy_start_idle", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Continuous mode, dwell=0: 0..7 repeating with no gap, done on each sel=7.
    dwell = 8'd0; cont = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      expect_out($sformatf("cont_c%0d", k), 3'(k % 8), 1'b1, 1'b1, ((k % 8) == 7), 1'b0);
      step();
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    expect_out("cont_stop", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Stop mid-dwell on channel 4, then start and stop together.
    dwell = 8'd3; cont = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 17; k++) begin
      expect_out($sformatf("stop_run_c%0d", k), 3'(k / 4), 1'b1, 1'b1, 1'b0, 1'b0);
      step();
    end
    expect_out("stop_ch4", 3'd4, 1'b1, 1'b1, 1'b0, 1'b0);
    stop = 1'b1;
    step();
    stop = 1'b0;
    expect_out("stop_idle", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    expect_out("stop_no_done", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    expect_out("start_stop_same", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    expect_out("start_stop_after", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset mid-scan on channel 6, then reset together with start.
    dwell = 8'd1; cont = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 13; k++) begin
      expect_out($sformatf("rst_run_c%0d", k), 3'(k / 2), 1'b1, 1'b1, 1'b0, 1'b0);
      step();
    end
    expect_out("rst_ch6", 3'd6, 1'b1, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    expect_out("rst_mid_scan", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1; start = 1'b1;
    step();
    rst = 1'b0; start = 1'b0;
    expect_out("rst_over_start", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    expect_out("rst_over_start2", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

`ifdef SEL_SEQ_SKIP_EN
    // Sparse mask in continuous mode: 2,5,7 repeating.
    mask = 8'b1010_0100; dwell = 8'd0; cont = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 9; k++) begin
      expect_out($sformatf("skip_c%0d", k), seq31[k % 3], 1'b1, 1'b1, ((k % 3) == 2), 1'b0);
      step();
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    expect_out("skip_stop", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Empty mask is rejected with a one-cycle err pulse.
    mask = 8'h00; start = 1'b1;
    step();
    start = 1'b0;
    expect_out("empty_err", 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    expect_out("empty_err_clr", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Single channel in continuous mode: sel constant, done every dwell+1 cycles.
    mask = 8'h08; dwell = 8'd2; cont = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 9; k++) begin
      expect_out($sformatf("single_c%0d", k), 3'd3, 1'b1, 1'b1, ((k % 3) == 2), 1'b0);
      step();
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    expect_out("single_stop", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
`else
    // Mask is ignored: an empty mask still starts a full scan from channel 0.
    mask = 8'h00; dwell = 8'd0; cont = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      expect_out($sformatf("nomask_c%0d", k), 3'(k), 1'b1, 1'b1, (k == 7), 1'b0);
      step();
    end
    expect_out("nomask_idle", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
